// File: rtl/contador_pkg.sv
// contador_pkg: shared direction encoding and modulus-zero constant for the programmable-modulus counter
package contador_pkg;
  typedef enum logic {SOBE = 1'b0, DESCE = 1'b1} dir_t;
  localparam int MOD_ZERO = 0;
endpackage

// File: rtl/contador_limites.sv
// contador_limites: limit = M-1 (M == 0 means 2^N), fim/inicio/atinge compares, load range check; ports q, m, marca, dado -> limite, fim, inicio, atinge, fora
module contador_limites
  import contador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  input  logic [N-1:0] marca,
  input  logic [N-1:0] dado,
  output logic [N-1:0] limite,
  output logic         fim,
  output logic         inicio,
  output logic         atinge,
  output logic         fora
);
  assign limite = (m == N'(MOD_ZERO)) ? '1 : m - N'(1);
  assign fim    = q == limite;
  assign inicio = q == '0;
  assign atinge = q == marca;
  assign fora   = dado > limite;
endmodule

// File: rtl/contador_mod_prog.sv
// contador_mod_prog: up/down counter with programmable modulus, load range check, wrap/error pulses; optional saturation via CONTADOR_MOD_PROG_SATURA_EN
// ports: clock, zera_n (sync active-low reset), zera_s, conta, desce, carrega, dado, define_m, modulo, marca, satura -> Q, fim, inicio, atinge, vai_um, erro_carga
module contador_mod_prog
  import contador_pkg::*;
#(
  parameter int N     = 8,
  parameter int M_INI = 100
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         zera_s,
  input  logic         conta,
  input  logic         desce,
  input  logic         carrega,
  input  logic [N-1:0] dado,
  input  logic         define_m,
  input  logic [N-1:0] modulo,
  input  logic [N-1:0] marca,
  input  logic         satura,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         inicio,
  output logic         atinge,
  output logic         vai_um,
  output logic         erro_carga
);
  logic [N-1:0] m, limite;
  logic fora, sat, borda;
  dir_t dir;
  contador_limites #(.N(N)) u_limites (
    .q(Q), .m(m), .marca(marca), .dado(dado),
    .limite(limite), .fim(fim), .inicio(inicio), .atinge(atinge), .fora(fora)
  );
`ifdef CONTADOR_MOD_PROG_SATURA_EN
  assign sat = satura;
`else
  assign sat = satura & 1'b0;
`endif
  assign dir   = dir_t'(desce);
  assign borda = (dir == SOBE) ? fim : inicio;
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      Q          <= '0;
      m          <= N'(M_INI);
      vai_um     <= 1'b0;
      erro_carga <= 1'b0;
    end else begin
      vai_um     <= 1'b0;
      erro_carga <= 1'b0;
      if (zera_s) Q <= '0;
      else if (define_m) begin
        m <= modulo;
        Q <= '0;
      end else if (carrega) begin
        Q          <= fora ? limite : dado;
        erro_carga <= fora;
      end else if (conta) begin
        if (!borda) Q <= (dir == SOBE) ? Q + N'(1) : Q - N'(1);
        else if (!sat) begin
          Q      <= (dir == SOBE) ? '0 : limite;
          vai_um <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_contador_mod_prog.sv
// tb_contador_mod_prog: randomized and directed bench against a behavioural counter model
module tb_contador_mod_prog;
  localparam int N = 8;
  localparam int M_INI = 100;
  localparam int FULL = 1 << N;
`ifdef CONTADOR_MOD_PROG_SATURA_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic clock = 0;
  logic zera_n, zera_s, conta, desce, carrega, define_m, satura;
  logic [N-1:0] dado, modulo, marca, Q;
  logic fim, inicio, atinge, vai_um, erro_carga;
  int checks = 0, errors = 0;
  int mq, mm, mv, me;
  contador_mod_prog #(.N(N), .M_INI(M_INI)) dut (
    .clock(clock), .zera_n(zera_n), .zera_s(zera_s), .conta(conta), .desce(desce),
    .carrega(carrega), .dado(dado), .define_m(define_m), .modulo(modulo), .marca(marca),
    .satura(satura), .Q(Q), .fim(fim), .inicio(inicio), .atinge(atinge),
    .vai_um(vai_um), .erro_carga(erro_carga)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int lim();
    return (mm == 0 ? FULL : mm) - 1;
  endfunction
  task automatic step();
    mv = 0;
    me = 0;
    if (!zera_n) begin
      mq = 0;
      mm = M_INI;
    end else if (zera_s) mq = 0;
    else if (define_m) begin
      mm = int'(modulo);
      mq = 0;
    end else if (carrega) begin
      if (int'(dado) > lim()) begin
        mq = lim();
        me = 1;
      end else mq = int'(dado);
    end else if (conta) begin
      if (!desce) begin
        if (mq < lim()) mq++;
        else if (!(SAT_EN && satura)) begin
          mq = 0;
          mv = 1;
        end
      end else begin
        if (mq > 0) mq--;
        else if (!(SAT_EN && satura)) begin
          mq = lim();
          mv = 1;
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clock);
    step();
    #1;
    chk("Q", int'(Q), mq);
    chk("fim", int'(fim), int'(mq == lim()));
    chk("inicio", int'(inicio), int'(mq == 0));
    chk("atinge", int'(atinge), int'(mq == int'(marca)));
    chk("vai_um", int'(vai_um), mv);
    chk("erro_carga", int'(erro_carga), me);
  endtask
  task automatic idle();
    zera_n = 1; zera_s = 0; conta = 0; desce = 0; carrega = 0; define_m = 0; satura = 0;
  endtask
  initial begin
    mq = 0; mm = M_INI; mv = 0; me = 0;
    idle();
    dado = 0; modulo = 0; marca = 200;
    zera_n = 0;
    tick();
    chk("rst_q", int'(Q), 0);
    zera_n = 1; conta = 1;
    for (int i = 0; i < 99; i++) tick();
    chk("q99", int'(Q), 99);
    chk("fim99", int'(fim), 1);
    tick();
    chk("wrap_q", int'(Q), 0);
    chk("wrap_v", int'(vai_um), 1);
    tick();
    chk("wrap_v_off", int'(vai_um), 0);
    idle(); carrega = 1; dado = 57; tick();
    idle(); define_m = 1; modulo = 10; tick();
    idle(); conta = 1; desce = 1; tick();
    chk("down_q", int'(Q), 9);
    chk("down_v", int'(vai_um), 1);
    idle(); carrega = 1; dado = 7; tick();
    chk("ld7", int'(Q), 7);
    dado = 12; tick();
    chk("ld12", int'(Q), 9);
    chk("ld12_e", int'(erro_carga), 1);
    idle(); dado = 5; carrega = 1; tick();
    idle(); zera_s = 1; define_m = 1; carrega = 1; conta = 1; modulo = 20; tick();
    chk("pri_q", int'(Q), 0);
    idle(); define_m = 1; carrega = 1; modulo = 20; dado = 15; tick();
    chk("pri_dm", int'(Q), 0);
    idle(); carrega = 1; dado = 19; tick();
    chk("pri_m20", int'(Q), 19);
    idle(); define_m = 1; modulo = 0; tick();
    idle(); carrega = 1; dado = 255; tick();
    idle(); conta = 1; tick();
    chk("m0_wrap", int'(Q), 0);
    chk("m0_v", int'(vai_um), 1);
    idle(); define_m = 1; modulo = 1; tick();
    idle(); conta = 1;
    for (int i = 0; i < 4; i++) begin
      desce = i[0];
      tick();
      chk("m1_v", int'(vai_um), 1);
    end
    idle(); define_m = 1; modulo = 10; marca = 3; tick();
    idle(); conta = 1;
    for (int i = 0; i < 10; i++) tick();
    idle(); carrega = 1; dado = 8; tick();
    idle(); conta = 1; satura = 1;
    tick(); tick();
    chk("sat_q", int'(Q), SAT_EN ? 9 : 0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      zera_n   = ($urandom_range(0, 99) != 0);
      zera_s   = ($urandom_range(0, 29) == 0);
      define_m = ($urandom_range(0, 39) == 0);
      carrega  = ($urandom_range(0, 9) == 0);
      conta    = ($urandom_range(0, 3) != 0);
      desce    = 1'($urandom_range(0, 1));
      satura   = 1'($urandom_range(0, 1));
      dado     = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 12));
      modulo   = 8'($urandom_range(0, 2) == 0 ? $urandom_range(0, 3) : $urandom);
      marca    = 8'($urandom_range(0, 12));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
